// File: rtl/instruction_encoder.sv
// Packs instruction field tuples into 33-bit words and streams them into instruction memory.
// Optional macro ENC_ILLEGAL_CHECK_EN drops undefined opcodes and pulses err instead of writing.
module instruction_encoder #(
  parameter int MEM_ADDR_BITS     = 8,
  parameter int INSTRUCTION_WIDTH = 33,
  parameter int WIDTH_OPCODE      = 5,
  parameter int REGFILE_ADDR_BITS = 4,
  parameter int IMMEDIATE_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [MEM_ADDR_BITS-1:0]     base_addr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH_OPCODE-1:0]      in_opcode,
  input  logic [REGFILE_ADDR_BITS-1:0] in_dest,
  input  logic [REGFILE_ADDR_BITS-1:0] in_src1,
  input  logic [REGFILE_ADDR_BITS-1:0] in_src2,
  input  logic [IMMEDIATE_WIDTH-1:0]   in_imm,
  output logic                         wr_en,
  output logic [MEM_ADDR_BITS-1:0]     wr_addr,
  output logic [INSTRUCTION_WIDTH-1:0] wr_data,
  output logic                         done,
  output logic                         err
);

  localparam logic [WIDTH_OPCODE-1:0] INSTR_NOP  = 5'd0;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_LR   = 5'd1;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_LI   = 5'd2;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_SR   = 5'd3;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_MOVE = 5'd4;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_ADD  = 5'd5;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_ADDI = 5'd6;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_SUB  = 5'd7;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_AND  = 5'd8;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_OR   = 5'd9;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_NOT  = 5'd10;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_SHL  = 5'd11;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_SHR  = 5'd12;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_BE   = 5'd13;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_BNE  = 5'd14;
  localparam logic [WIDTH_OPCODE-1:0] INSTR_CMP  = 5'd15;

  localparam logic [MEM_ADDR_BITS-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } state_t;

  // Zero the fields that the opcode's format does not use.
  function automatic logic [INSTRUCTION_WIDTH-1:0] encode(
    input logic [WIDTH_OPCODE-1:0]      op,
    input logic [REGFILE_ADDR_BITS-1:0] d,
    input logic [REGFILE_ADDR_BITS-1:0] s1,
    input logic [REGFILE_ADDR_BITS-1:0] s2,
    input logic [IMMEDIATE_WIDTH-1:0]   imm
  );
    logic [REGFILE_ADDR_BITS-1:0] d_k, s1_k, s2_k;
    logic [IMMEDIATE_WIDTH-1:0]   imm_k;
    d_k   = d;
    s1_k  = s1;
    s2_k  = s2;
    imm_k = imm;
    case (op)
      INSTR_NOP: begin
        d_k   = '0;
        s1_k  = '0;
        s2_k  = '0;
        imm_k = '0;
      end
      INSTR_ADD, INSTR_SUB, INSTR_AND, INSTR_OR: imm_k = '0;
      INSTR_MOVE, INSTR_NOT: begin
        s2_k  = '0;
        imm_k = '0;
      end
      INSTR_LR, INSTR_SR, INSTR_SHL, INSTR_SHR, INSTR_BE, INSTR_BNE: s2_k = '0;
      INSTR_LI, INSTR_ADDI: begin
        s1_k = '0;
        s2_k = '0;
      end
      INSTR_CMP: begin
        d_k   = '0;
        imm_k = '0;
      end
      default: imm_k = imm;
    endcase
    return {op, d_k, s1_k, s2_k, imm_k};
  endfunction

`ifdef ENC_ILLEGAL_CHECK_EN
  function automatic logic is_defined(input logic [WIDTH_OPCODE-1:0] op);
    case (op)
      INSTR_NOP, INSTR_LR, INSTR_LI, INSTR_SR, INSTR_MOVE, INSTR_ADD,
      INSTR_ADDI, INSTR_SUB, INSTR_AND, INSTR_OR, INSTR_NOT, INSTR_SHL,
      INSTR_SHR, INSTR_BE, INSTR_BNE, INSTR_CMP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic opcode_legal;
  assign opcode_legal = is_defined(in_opcode);
`else
  logic opcode_legal;
  assign opcode_legal = 1'b1;
`endif

  state_t                         state_q;
  logic [MEM_ADDR_BITS-1:0]       addr_q;
  logic                           in_ready_q;
  logic                           wr_en_q;
  logic [MEM_ADDR_BITS-1:0]       wr_addr_q;
  logic [INSTRUCTION_WIDTH-1:0]   wr_data_q;
  logic                           done_q;
  logic                           err_q;
  logic [INSTRUCTION_WIDTH-1:0]   word_d;

  assign word_d = encode(in_opcode, in_dest, in_src1, in_src2, in_imm);

  // Control FSM with registered handshake, write and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE, FULL: begin
          if (start) begin
            state_q    <= RUN;
            addr_q     <= base_addr;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        RUN: begin
          // A reload wins over a tuple presented in the same cycle.
          if (start) begin
            addr_q <= base_addr;
          end else if (in_valid && in_ready_q) begin
            if (opcode_legal) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= addr_q;
              wr_data_q <= word_d;
              if (addr_q == ADDR_LAST) begin
                state_q    <= FULL;
                in_ready_q <= 1'b0;
                done_q     <= 1'b1;
              end else begin
                addr_q <= addr_q + {{(MEM_ADDR_BITS-1){1'b0}}, 1'b1};
              end
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: a field-level reference model predicts every write
// and err pulse; a negedge monitor compares them and the ready/done levels each cycle.
module tb_instruction_encoder;

  localparam int AW       = 8;
  localparam int ADDR_MAX = (1 << AW) - 1;
`ifdef ENC_ILLEGAL_CHECK_EN
  localparam bit CHK_ILLEGAL = 1'b1;
`else
  localparam bit CHK_ILLEGAL = 1'b0;
`endif

  localparam logic [32:0] M_OP  = 33'h1F0000000;
  localparam logic [32:0] M_D   = 33'h00F000000;
  localparam logic [32:0] M_S1  = 33'h000F00000;
  localparam logic [32:0] M_S2  = 33'h0000F0000;
  localparam logic [32:0] M_IMM = 33'h00000FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_opcode = '0;
  logic [3:0]    in_dest = '0, in_src1 = '0, in_src2 = '0;
  logic [15:0]   in_imm = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [32:0]   wr_data;
  logic          done;
  logic          err;

  instruction_encoder #(.MEM_ADDR_BITS(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_dest(in_dest), .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [7:0]  addr;
    logic [32:0] data;
  } exp_t;

  exp_t        q[$];
  int          n_pass = 0;
  int          n_total = 0;
  bit          m_run = 1'b0;
  bit          m_full = 1'b0;
  int          m_next = 0;
  logic [7:0]  last_addr = '0;
  logic [32:0] last_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Which fields each opcode keeps; anything undefined keeps everything.
  function automatic logic [32:0] ref_word(input logic [4:0] op, input logic [3:0] d,
                                          input logic [3:0] s1, input logic [3:0] s2,
                                          input logic [15:0] imm);
    logic [32:0] keep;
    case (op)
      5'd0:                             keep = 33'h0;
      5'd5, 5'd7, 5'd8, 5'd9:           keep = M_OP | M_D | M_S1 | M_S2;
      5'd4, 5'd10:                      keep = M_OP | M_D | M_S1;
      5'd1, 5'd3, 5'd11, 5'd12, 5'd13, 5'd14: keep = M_OP | M_D | M_S1 | M_IMM;
      5'd2, 5'd6:                       keep = M_OP | M_D | M_IMM;
      5'd15:                            keep = M_OP | M_S1 | M_S2;
      default:                          keep = '1;
    endcase
    return {op, d, s1, s2, imm} & keep;
  endfunction

  task automatic cycle(input bit st, input int ba, input bit v, input logic [4:0] op,
                       input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [15:0] imm);
    exp_t e;
    start = st; base_addr = ba[AW-1:0]; in_valid = v;
    in_opcode = op; in_dest = d; in_src1 = s1; in_src2 = s2; in_imm = imm;
    @(posedge clk);
    if (st) begin
      m_run = 1'b1; m_full = 1'b0; m_next = ba;
    end else if (m_run && v) begin
      if (CHK_ILLEGAL && op > 5'd15) begin
        e.is_err = 1'b1; e.addr = '0; e.data = '0;
        q.push_back(e);
      end else begin
        e.is_err = 1'b0; e.addr = m_next[7:0]; e.data = ref_word(op, d, s1, s2, imm);
        q.push_back(e);
        if (m_next == ADDR_MAX) begin
          m_run = 1'b0; m_full = 1'b1;
        end else m_next++;
      end
    end
    #1;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 0, 1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 16'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wr_addr", wr_addr, 8'h00);
    chk("rst_wr_data", wr_data, 33'h0);
    q.delete();
    m_run = 1'b0; m_full = 1'b0; m_next = 0;
    last_addr = '0; last_data = '0;
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: pop one expectation per cycle with output activity, otherwise demand silence and hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.is_err) begin
          chk("err_pulse", err, 1'b1);
          chk("err_no_wr", wr_en, 1'b0);
        end else begin
          chk("wr_en", wr_en, 1'b1);
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
          chk("wr_err_low", err, 1'b0);
          last_addr = e.addr; last_data = e.data;
        end
      end else begin
        chk("wr_en_idle", wr_en, 1'b0);
        chk("err_idle", err, 1'b0);
        chk("wr_addr_hold", wr_addr, last_addr);
        chk("wr_data_hold", wr_data, last_data);
      end
      chk("in_ready", in_ready, m_run);
      chk("done", done, m_full);
    end
  end

  initial begin
    logic [4:0] rop;
    @(posedge clk); #1;
    apply_reset();

    // Tuple while idle is ignored.
    cycle(1'b0, 0, 1'b1, 5'd2, 4'd1, 4'd0, 4'd0, 16'h1234);

    // LR R1,R0,0x0010 at base 0.
    cycle(1'b1, 0, 1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 16'd0);
    cycle(1'b0, 0, 1'b1, 5'd1, 4'd1, 4'd0, 4'd0, 16'h0010);
    idle_cycle();

    // Back-to-back program from base 0.
    cycle(1'b1, 0, 1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 16'd0);
    cycle(1'b0, 0, 1'b1, 5'd2, 4'd1, 4'd0, 4'd0, 16'h0000);
    cycle(1'b0, 0, 1'b1, 5'd2, 4'd2, 4'd0, 4'd0, 16'h0000);
    cycle(1'b0, 0, 1'b1, 5'd2, 4'd3, 4'd0, 4'd0, 16'h000A);
    cycle(1'b0, 0, 1'b1, 5'd5, 4'd2, 4'd2, 4'd1, 16'h0000);
    cycle(1'b0, 0, 1'b1, 5'd6, 4'd1, 4'd0, 4'd0, 16'h0001);
    cycle(1'b0, 0, 1'b1, 5'd14, 4'd1, 4'd3, 4'd0, 16'hFFFD);

    // Masked fields: ADD with imm, LI with src1.
    cycle(1'b0, 0, 1'b1, 5'd5, 4'd2, 4'd2, 4'd1, 16'hBEEF);
    cycle(1'b0, 0, 1'b1, 5'd2, 4'd3, 4'hF, 4'd0, 16'h000A);
    cycle(1'b0, 0, 1'b1, 5'd15, 4'h7, 4'h5, 4'h6, 16'hAAAA);

    // Start collides with a valid tuple: reload wins.
    cycle(1'b1, 8'h40, 1'b1, 5'd5, 4'd1, 4'd1, 4'd1, 16'd0);
    cycle(1'b0, 0, 1'b1, 5'd7, 4'd4, 4'd5, 4'd6, 16'h1111);

    // Fill the top of memory: five tuples, four writes, then full.
    cycle(1'b1, ADDR_MAX - 3, 1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 16'd0);
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 0, 1'b1, 5'd6, i[3:0], 4'd0, 4'd0, 16'(i));
    idle_cycle();
    cycle(1'b1, 8'h10, 1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 16'd0);
    cycle(1'b0, 0, 1'b1, 5'd9, 4'd1, 4'd2, 4'd3, 16'h5555);

    // Undefined opcode between two NOPs.
    cycle(1'b1, 0, 1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 16'd0);
    cycle(1'b0, 0, 1'b1, 5'd0, 4'hF, 4'hF, 4'hF, 16'hFFFF);
    cycle(1'b0, 0, 1'b1, 5'h1F, 4'h1, 4'h2, 4'h3, 16'h4567);
    cycle(1'b0, 0, 1'b1, 5'd0, 4'd0, 4'd0, 4'd0, 16'd0);
    idle_cycle();

    // Randomized traffic, including base addresses close to the top.
    for (int i = 0; i < 600; i++) begin
      rop = 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 99) < 4), ($urandom_range(0, 1) == 1) ? int'($urandom_range(240, 255))
                                                                        : int'($urandom_range(0, 255)),
            ($urandom_range(0, 99) < 75), rop, 4'($urandom), 4'($urandom), 4'($urandom),
            16'($urandom));
    end

    // Reset in mid-stream, right after a write has been issued.
    cycle(1'b1, 0, 1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 16'd0);
    cycle(1'b0, 0, 1'b1, 5'd2, 4'd5, 4'd0, 4'd0, 16'h0042);
    apply_reset();
    idle_cycle();
    cycle(1'b1, 8'h20, 1'b0, 5'd0, 4'd0, 4'd0, 4'd0, 16'd0);
    cycle(1'b0, 0, 1'b1, 5'd8, 4'd1, 4'd2, 4'd3, 16'h7777);
    idle_cycle();
    idle_cycle();

    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL take parameter MEM_ADDR_BITS, default 8, which sets the instruction-memory write address width.
REQ-002 SHALL take INSTRUCTION_WIDTH (33), WIDTH_OPCODE (5), REGFILE_ADDR_BITS (4), IMMEDIATE_WIDTH (16) and all INSTR_* opcodes from params.v.
REQ-003 clk  in  1  sole clock; all state on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle pulse that loads base_addr and clears done.
REQ-006 base_addr  in  MEM_ADDR_BITS  first write address.
REQ-007 in_valid  in  1  field tuple present.
REQ-008 in_ready  out  1  encoder can accept a tuple.
REQ-009 in_opcode/in_dest/in_src1/in_src2/in_imm  in  5/4/4/4/16  instruction fields.
REQ-010 wr_en  out  1  instruction-memory write strobe.
REQ-011 wr_addr  out  MEM_ADDR_BITS  write address.
REQ-012 wr_data  out  33  encoded instruction word.
REQ-013 done  out  1  memory full, level.
REQ-014 err  out  1  one-cycle illegal-instruction pulse.

Function
REQ-015 Word layout SHALL be: opcode [32:28], dest [27:24], src1 [23:20], src2 [19:16], imm [15:0].
REQ-016 Field masking by format; masked fields SHALL be zero:
- NOP: all fields zero.
- ADD/SUB/AND/OR: dest, src1, src2 kept; imm zero.
- MOVE/NOT: dest, src1 kept.
- LR/SR/SHL/SHR/BE/BNE: dest, src1, imm kept; src2 zero.
- LI/ADDI: dest, imm kept.
- CMP: src1, src2 kept.
REQ-017 FSM states SHALL be IDLE, RUN and FULL; reset enters IDLE.
REQ-018 IDLE: in_ready=0; start -> RUN, with the address counter set to base_addr.
REQ-019 RUN: in_ready=1; a tuple is accepted on the cycle in_valid&&in_ready.
REQ-020 An accepted tuple SHALL be registered and appear on wr_data/wr_addr with wr_en=1 exactly one cycle after acceptance (latency 1).
REQ-021 Back-to-back acceptance SHALL sustain one write per cycle with no bubbles.
REQ-022 The address counter SHALL increment by 1 after each write.
REQ-023 A write to address 2^MEM_ADDR_BITS-1 SHALL move the FSM to FULL in the same cycle as that write; the counter does not wrap.
REQ-024 FULL: in_ready=0, done=1; start -> RUN with the counter reloaded from base_addr and done cleared.
REQ-025 start in RUN SHALL take priority over a simultaneous handshake: the tuple is not accepted and the counter is reloaded.
REQ-026 wr_en SHALL be low on every cycle without a registered accept; wr_data and wr_addr hold their last values.

Reset
REQ-027 When rst_n is low, the block SHALL immediately drive: state IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, done=0, err=0.
REQ-028 A reset during RUN SHALL abort any pending write; no wr_en is issued after rst_n falls.

Configuration
REQ-029 Macro ENC_ILLEGAL_CHECK_EN SHALL select illegal-opcode handling.
REQ-030 With ENC_ILLEGAL_CHECK_EN defined, an accepted opcode matching no INSTR_* constant SHALL:
- produce no write;
- leave the counter unchanged;
- pulse err for one cycle, aligned with where wr_en would have been.
REQ-031 Without ENC_ILLEGAL_CHECK_EN, an undefined opcode SHALL be packed with all fields unmasked and written normally, and err SHALL be tied to 0.

Verification
REQ-032 start with base_addr=0x00, tuple LR dest=1 src1=0 imm=0x0010 -> next cycle wr_en=1, wr_addr=0x00, wr_data=0x011000010.
REQ-033 Back-to-back LI R1,0x0; LI R2,0x0; LI R3,0x0A; ADD R2,R2,R1; ADDI R1,0x1; BNE R1,R3,0xFFFD -> six consecutive writes at 0x00-0x05 of 0x021000000, 0x022000000, 0x02300000A, 0x052210000, 0x061000001, 0x0E130FFFD.
REQ-034 ADD with in_imm=0xBEEF, and LI with in_src1=0xF -> the masked fields are zero: 0x052210000 and 0x02300000A respectively.
REQ-035 MEM_ADDR_BITS=2, base_addr=0, five valid tuples -> four writes at 0-3, done=1, in_ready=0, fifth tuple not accepted; then start -> done=0, next write at base_addr.
REQ-036 With ENC_ILLEGAL_CHECK_EN, opcode 0x1F between two NOPs -> writes at 0 and 1 only, one err pulse; with rst_n pulled low mid-stream -> all outputs zero immediately.
